// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: framebuffer read port between the scan controller and the framebuffer
//   fb_rd   : one-cycle read strobe (controller -> framebuffer)
//   fb_addr : row index being read (controller -> framebuffer)
//   fb_data : row pixels, valid the cycle after fb_rd, MSB = leftmost column (framebuffer -> controller)
interface matrix_scan_ctrl_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
);
  logic                    fb_rd;
  logic [$clog2(ROWS)-1:0] fb_addr;
  logic [COLS-1:0]         fb_data;
  modport master (output fb_rd, fb_addr, input fb_data);
  modport slave (input fb_rd, fb_addr, output fb_data);
endinterface

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: row-scan controller for a ROWSxCOLS LED matrix fed from a framebuffer read port
//   clk, reset_n : system clock, asynchronous active-low reset
//   enable       : run scanning; dropping it stops at the next row boundary
//   fb           : framebuffer read port (fb_rd/fb_addr out, fb_data in)
//   frame_start  : one-cycle pulse when row 0 is fetched
//   CSDI/CCLK    : column serial data / shift clock
//   RSDI/RCLK    : row walking-one data / shift clock
//   LE, OEB      : column latch enable, active-low output enable
module matrix_scan_ctrl #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int CLKDIV = 1,
  parameter int HOLD   = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  matrix_scan_ctrl_if.master fb,
  output logic               frame_start,
  output logic               CSDI,
  output logic               CCLK,
  output logic               RSDI,
  output logic               RCLK,
  output logic               LE,
  output logic               OEB
);
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(COLS + 1);
  localparam int DW = $clog2(CLKDIV + 1);
  localparam int HW = $clog2(HOLD + 1);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, BLANK, ROWCLK, LATCH, HOLDST} state_t;
  state_t          r_state, w_state;
  logic [RW-1:0]   r_row, w_row;
  logic [COLS-1:0] r_sreg, w_sreg;
  logic [BW-1:0]   r_bcnt, w_bcnt;
  logic [DW-1:0]   r_dcnt, w_dcnt;
  logic [HW-1:0]   r_hcnt, w_hcnt;
  logic            r_lit, w_lit, r_ph, w_ph, w_div_end;
  logic            r_fb_rd, r_fs, r_csdi, r_cclk, r_rsdi, r_rclk, r_le, r_oeb;
  logic            w_fb_rd, w_fs, w_csdi, w_cclk, w_rsdi, w_rclk, w_le, w_oeb;
  assign w_div_end = r_dcnt == DW'(CLKDIV - 1);
  // Outputs are decoded from the next-state values and registered, so each
  // pin changes on the same edge as the state it belongs to.
  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_lit   = r_lit;
    w_ph    = r_ph;
    w_sreg  = r_sreg;
    w_bcnt  = r_bcnt;
    w_hcnt  = r_hcnt;
    // Divider runs modulo CLKDIV; every state that times with it is entered with it at 0.
    w_dcnt  = w_div_end ? '0 : r_dcnt + DW'(1);
    case (r_state)
      IDLE: begin
        w_row = '0;
        w_lit = 1'b0;
        if (enable) w_state = FETCH;
      end
      FETCH: w_state = CAPTURE;
      CAPTURE: begin
        w_state = SHIFT;
        w_sreg  = fb.fb_data;
        w_bcnt  = '0;
        w_dcnt  = '0;
        w_ph    = 1'b0;
      end
      SHIFT: if (w_div_end) begin
        w_ph = ~r_ph;
        if (r_ph) begin
          w_sreg = r_sreg << 1;
          w_bcnt = r_bcnt + BW'(1);
          if (r_bcnt == BW'(COLS - 1)) w_state = BLANK;
        end
      end
      BLANK: begin
        w_state = ROWCLK;
        w_dcnt  = '0;
      end
      ROWCLK: if (w_div_end) w_state = LATCH;
      LATCH: if (w_div_end) begin
        w_state = HOLDST;
        w_lit   = 1'b1;
        w_hcnt  = '0;
      end
      HOLDST: begin
        w_hcnt = r_hcnt + HW'(1);
        if (r_hcnt == HW'(HOLD - 1)) begin
          w_row   = r_row == RW'(ROWS - 1) ? '0 : r_row + RW'(1);
          w_state = enable ? FETCH : IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    w_fb_rd = w_state == FETCH;
    w_fs    = w_state == FETCH && w_row == '0;
    w_csdi  = w_state == SHIFT && w_sreg[COLS-1];
    w_cclk  = w_state == SHIFT && w_ph;
    w_rsdi  = (w_state == BLANK || w_state == ROWCLK) && w_row == '0;
    w_rclk  = w_state == ROWCLK;
    w_le    = w_state == LATCH;
    // The previous row stays lit while the next one is fetched and shifted.
    w_oeb   = (w_state inside {FETCH, CAPTURE, SHIFT, HOLDST}) ? ~w_lit : 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_lit   <= 1'b0;
      r_ph    <= 1'b0;
      r_sreg  <= '0;
      r_bcnt  <= '0;
      r_dcnt  <= '0;
      r_hcnt  <= '0;
      r_fb_rd <= 1'b0;
      r_fs    <= 1'b0;
      r_csdi  <= 1'b0;
      r_cclk  <= 1'b0;
      r_rsdi  <= 1'b0;
      r_rclk  <= 1'b0;
      r_le    <= 1'b0;
      r_oeb   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_lit   <= w_lit;
      r_ph    <= w_ph;
      r_sreg  <= w_sreg;
      r_bcnt  <= w_bcnt;
      r_dcnt  <= w_dcnt;
      r_hcnt  <= w_hcnt;
      r_fb_rd <= w_fb_rd;
      r_fs    <= w_fs;
      r_csdi  <= w_csdi;
      r_cclk  <= w_cclk;
      r_rsdi  <= w_rsdi;
      r_rclk  <= w_rclk;
      r_le    <= w_le;
      r_oeb   <= w_oeb;
    end
  assign fb.fb_rd    = r_fb_rd;
  assign fb.fb_addr  = r_row;
  assign frame_start = r_fs;
  assign CSDI        = r_csdi;
  assign CCLK        = r_cclk;
  assign RSDI        = r_rsdi;
  assign RCLK        = r_rclk;
  assign LE          = r_le;
  assign OEB         = r_oeb;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: directed bench for matrix_scan_ctrl (CLKDIV=1/HOLD=4 and CLKDIV=3/HOLD=1 instances)
module tb_matrix_scan_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, en_a = 1'b1, en_b = 1'b0;
  logic fs_a, csdi_a, cclk_a, rsdi_a, rclk_a, le_a, oeb_a;
  logic fs_b, csdi_b, cclk_b, rsdi_b, rclk_b, le_b, oeb_b;
  int total = 0, bad = 0;
  logic [15:0] mem [16];
  logic [15:0] word = '0;
  int rises = 0, rclk_n = 0, le_n = 0, oeb_lo = 0, ovl = 0, le_at = -1, first_lo = -1, oeb_hi1 = 0;
  int fetch_at[$], fs_at[$], fetch_b[$];
  logic [3:0] addr_q[$];
  logic rs_q[$];
  logic pc = 1'b0, pr = 1'b0;
  int cnt, b_cclk = 0, b_rises = 0, b_rclk = 0, b_le = 0, b_oeb = 0, last_rise = 0, pmin = 999, pmax = 0;
  matrix_scan_ctrl_if #(.ROWS(16), .COLS(16)) fa ();
  matrix_scan_ctrl_if #(.ROWS(16), .COLS(16)) fbi ();
  matrix_scan_ctrl #(.ROWS(16), .COLS(16), .CLKDIV(1), .HOLD(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .fb(fa), .frame_start(fs_a),
    .CSDI(csdi_a), .CCLK(cclk_a), .RSDI(rsdi_a), .RCLK(rclk_a), .LE(le_a), .OEB(oeb_a));
  matrix_scan_ctrl #(.ROWS(16), .COLS(16), .CLKDIV(3), .HOLD(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .fb(fbi), .frame_start(fs_b),
    .CSDI(csdi_b), .CCLK(cclk_b), .RSDI(rsdi_b), .RCLK(rclk_b), .LE(le_b), .OEB(oeb_b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (fa.fb_rd) fa.fb_data <= mem[fa.fb_addr];
    if (fbi.fb_rd) fbi.fb_data <= mem[fbi.fb_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int r = 0; r < 16; r++) mem[r] = 16'(r * 4369 + 7);
    mem[0] = 16'hA5C3;
    @(negedge clk);
    chk("reset_a", {fa.fb_rd, fa.fb_addr, fs_a, csdi_a, cclk_a, rsdi_a, rclk_a, le_a, oeb_a}, 12'h001);
    chk("reset_b", {fbi.fb_rd, fbi.fb_addr, fs_b, csdi_b, cclk_b, rsdi_b, rclk_b, le_b, oeb_b}, 12'h001);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_fetch", {fa.fb_rd, fa.fb_addr, fs_a}, 6'b100001);
    for (int n = 1; n <= 697; n++) begin
      if (n > 1) @(negedge clk);
      if (fa.fb_rd) begin
        fetch_at.push_back(n);
        addr_q.push_back(fa.fb_addr);
      end
      if (fs_a) fs_at.push_back(n);
      if (rclk_a && !pr) rs_q.push_back(rsdi_a);
      if (le_a && (cclk_a || rclk_a)) ovl++;
      if (n <= 41) begin
        if (cclk_a && !pc) begin
          word = {word[14:0], csdi_a};
          rises++;
        end
        rclk_n += int'(rclk_a);
        le_n += int'(le_a);
        oeb_lo += int'(!oeb_a);
        if (le_a) le_at = n;
        if (!oeb_a && first_lo < 0) first_lo = n;
      end
      if (n >= 42 && n <= 82) oeb_hi1 += int'(oeb_a);
      pc = cclk_a;
      pr = rclk_a;
    end
    chk("shift_word", word, 16'hA5C3);
    chk("cclk_rises", rises, 16);
    chk("rclk_cycles", rclk_n, 1);
    chk("le_cycles", le_n, 1);
    chk("le_cycle_pos", le_at, 37);
    chk("oeb_low_start", first_lo, 38);
    chk("oeb_low_cycles", oeb_lo, 4);
    chk("oeb_high_row1", oeb_hi1, 3);
    chk("le_overlap", ovl, 0);
    chk("fetch_count", fetch_at.size(), 17);
    if (fetch_at.size() > 1) chk("row_period", fetch_at[1] - fetch_at[0], 41);
    for (int i = 0; i < 17 && i < addr_q.size(); i++) chk($sformatf("addr_%0d", i), addr_q[i], i % 16);
    chk("rclk_pulses", rs_q.size(), 17);
    for (int i = 0; i < 17 && i < rs_q.size(); i++) chk($sformatf("rsdi_%0d", i), rs_q[i], i % 16 == 0);
    chk("fs_count", fs_at.size(), 2);
    if (fs_at.size() > 1) chk("frame_period", fs_at[1] - fs_at[0], 656);
    for (int i = 0; i < 200 && !(fa.fb_rd && fa.fb_addr == 4'd3); i++) @(negedge clk);
    chk("find_row3", fa.fb_rd && fa.fb_addr == 4'd3, 1'b1);
    repeat (10) @(negedge clk);
    chk("row3_in_shift", {fa.fb_rd, le_a, rclk_a}, 3'b000);
    en_a = 1'b0;
    for (int i = 0; i < 60 && !le_a; i++) @(negedge clk);
    chk("row3_latch", le_a, 1'b1);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(!oeb_a);
    end
    chk("row3_hold", cnt, 4);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(fa.fb_rd || !oeb_a);
    end
    chk("idle_dark", cnt, 0);
    en_a = 1'b1;
    @(negedge clk);
    chk("reenable_fetch", {fa.fb_rd, fa.fb_addr, fs_a}, 6'b100001);
    for (int i = 0; i < 60 && !(fa.fb_rd && fa.fb_addr == 4'd1); i++) @(negedge clk);
    chk("find_row1", fa.fb_rd && fa.fb_addr == 4'd1, 1'b1);
    for (int i = 0; i < 60 && !cclk_a; i++) @(negedge clk);
    chk("cclk_high", cclk_a, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", {fa.fb_addr, cclk_a, csdi_a, oeb_a}, 7'b0000001);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("restart_fetch", {fa.fb_rd, fa.fb_addr, fs_a}, 6'b100001);
    en_b = 1'b1;
    pc = 1'b0;
    for (int n = 1; n <= 213; n++) begin
      @(negedge clk);
      if (fbi.fb_rd) fetch_b.push_back(n);
      if (n == 1) chk("b_frame_start", fs_b, 1'b1);
      if (n >= 107 && n <= 212) begin
        b_cclk += int'(cclk_b);
        b_rclk += int'(rclk_b);
        b_le += int'(le_b);
        b_oeb += int'(oeb_b);
        if (cclk_b && !pc) begin
          b_rises++;
          if (last_rise > 0) begin
            pmin = (n - last_rise < pmin) ? n - last_rise : pmin;
            pmax = (n - last_rise > pmax) ? n - last_rise : pmax;
          end
          last_rise = n;
        end
      end
      pc = cclk_b;
    end
    chk("b_fetch_count", fetch_b.size(), 3);
    if (fetch_b.size() > 2) chk("b_row_period", fetch_b[2] - fetch_b[1], 106);
    chk("b_cclk_high", b_cclk, 48);
    chk("b_cclk_rises", b_rises, 16);
    chk("b_cclk_pmin", pmin, 6);
    chk("b_cclk_pmax", pmax, 6);
    chk("b_rclk_high", b_rclk, 3);
    chk("b_le_high", b_le, 3);
    chk("b_oeb_high", b_oeb, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
